// File: rtl/g_debounce_pkg.sv
// -----------------------------------------------------------------------------
// g_debounce_pkg
// Shared definitions for the g_debounce macro family.
//   state_t      : debouncer FSM encoding. Bit [1] is the debounced level, so
//                  the registered state bit can drive Q with no extra logic.
//   state_level  : helper returning the debounced level of a state.
//   SYNC_STAGES  : depth of the input synchronizer ahead of the FSM.
// -----------------------------------------------------------------------------
package g_debounce_pkg;

   typedef enum logic [1:0] {
      LOW    = 2'b00,
      CHK_HI = 2'b01,
      CHK_LO = 2'b10,
      HIGH   = 2'b11
   } state_t;

   localparam int SYNC_STAGES = 2;

   function automatic logic state_level(input state_t s);
      return s[1];
   endfunction

endpackage

// File: rtl/g_sync2.sv
// -----------------------------------------------------------------------------
// g_sync2
// Two-flop synchronizer for a single asynchronous level. Clocked on every CK
// edge with no enable so the sampled value is always fresh.
// Ports:
//   CK  : rising-edge clock
//   CDN : asynchronous active-low clear (both stages forced to 0)
//   D   : asynchronous input level
//   Q   : synchronized level (second stage)
// -----------------------------------------------------------------------------
module g_sync2 (
   input  logic CK,
   input  logic CDN,
   input  logic D,
   output logic Q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= D;
         r_s2 <= r_s1;
      end
   end

   assign Q = r_s2;

endmodule

// File: rtl/g_debounce.sv
// -----------------------------------------------------------------------------
// g_debounce
// Debounces a raw asynchronous level. The input is synchronized, then a
// four-state FSM requires the synchronized level to differ from Q on TERM+1
// consecutive enabled cycles (one to enter the check state, TERM more while
// the counter runs 0..TERM-1) before Q flips. Any enabled cycle that agrees
// with Q abandons the check without a strobe.
//
// Parameters:
//   CNT_W : qualification counter width
//   TERM  : qualifying enabled cycles in the check state, 1..2**CNT_W
// Ports:
//   CK        : rising-edge clock
//   CDN       : asynchronous active-low clear
//   CE        : clock enable for FSM and counter (synchronizer always runs)
//   D         : raw asynchronous level
//   Q         : debounced level (state register bit)
//   RISEN     : active-low one-cycle strobe, concurrent with Q first reading 1
//   FALLN     : active-low one-cycle strobe, concurrent with Q first reading 0
//   DBG_STATE : current FSM state, for observation only
//
// Handshake note: there is no valid/ready interface; RISEN/FALLN are pure
// registered pulses, low for exactly one CK cycle, never low together.
// -----------------------------------------------------------------------------
module g_debounce
   import g_debounce_pkg::*;
#(
   parameter int CNT_W = 4,
   parameter int TERM  = 4
) (
   input  logic   CK,
   input  logic   CDN,
   input  logic   CE,
   input  logic   D,
   output logic   Q,
   output logic   RISEN,
   output logic   FALLN,
   output state_t DBG_STATE
);

   // TERM-1 always fits CNT_W bits for legal TERM, so the counter never wraps.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERM - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             w_s2;
   logic             w_last;
   logic             w_rise_nxt;
   logic             w_fall_nxt;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_risen;
   logic             r_falln;

   g_sync2 u_sync (
      .CK  (CK),
      .CDN (CDN),
      .D   (D),
      .Q   (w_s2)
   );

   assign w_last = (r_cnt == CNT_LAST);

   // State register
   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         r_state <= LOW;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic; with CE low everything holds and w_s2 is ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (CE) begin
         case (r_state)
            LOW: begin
               if (w_s2) begin
                  w_state_nxt = CHK_HI;
                  w_cnt_nxt   = '0;
               end
            end
            CHK_HI: begin
               if (!w_s2) begin
                  w_state_nxt = LOW;
                  w_cnt_nxt   = '0;
               end else if (w_last) begin
                  w_state_nxt = HIGH;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
            HIGH: begin
               if (!w_s2) begin
                  w_state_nxt = CHK_LO;
                  w_cnt_nxt   = '0;
               end
            end
            CHK_LO: begin
               if (w_s2) begin
                  w_state_nxt = HIGH;
                  w_cnt_nxt   = '0;
               end else if (w_last) begin
                  w_state_nxt = LOW;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
            default: begin
               w_state_nxt = LOW;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Output logic: strobes are decoded from the qualifying transition only,
   // so abandoned checks and resets never pulse.
   always_comb begin
      w_rise_nxt = (r_state == CHK_HI) && (w_state_nxt == HIGH);
      w_fall_nxt = (r_state == CHK_LO) && (w_state_nxt == LOW);
   end

   // Strobe registers reload every edge, independent of CE, so a pulse is
   // always exactly one cycle wide.
   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         r_risen <= 1'b1;
         r_falln <= 1'b1;
      end else begin
         r_risen <= ~w_rise_nxt;
         r_falln <= ~w_fall_nxt;
      end
   end

   assign Q         = state_level(r_state);
   assign RISEN     = r_risen;
   assign FALLN     = r_falln;
   assign DBG_STATE = r_state;

endmodule

// File: tb/tb_g_debounce.sv
module tb_g_debounce;
   import g_debounce_pkg::*;

   // ---------------- clock / reset / stimulus signals ----------------
   logic CK  = 1'b0;
   logic CDN = 1'b0;
   logic CE  = 1'b1;
   logic D   = 1'b1;

   always #5 CK = ~CK;

   logic   q_o[3];
   logic   rn_o[3];
   logic   fn_o[3];
   state_t dbg[3];

   g_debounce #(.CNT_W(4), .TERM(4)) u_t4 (
      .CK(CK), .CDN(CDN), .CE(CE), .D(D),
      .Q(q_o[0]), .RISEN(rn_o[0]), .FALLN(fn_o[0]), .DBG_STATE(dbg[0]));
   g_debounce #(.CNT_W(4), .TERM(1)) u_t1 (
      .CK(CK), .CDN(CDN), .CE(CE), .D(D),
      .Q(q_o[1]), .RISEN(rn_o[1]), .FALLN(fn_o[1]), .DBG_STATE(dbg[1]));
   g_debounce #(.CNT_W(4), .TERM(16)) u_t16 (
      .CK(CK), .CDN(CDN), .CE(CE), .D(D),
      .Q(q_o[2]), .RISEN(rn_o[2]), .FALLN(fn_o[2]), .DBG_STATE(dbg[2]));

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int idx, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d got %0b expected %0b at %0t", name, idx, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Q flips after TERM+1 consecutive enabled cycles in which the synchronized
   // input (D delayed two edges) disagrees with Q; an agreeing enabled cycle
   // restarts the run, a disabled cycle leaves it alone.
   int   m_term[3] = '{4, 1, 16};
   logic m_s1, m_s2;
   logic m_q[3], m_rn[3], m_fn[3];
   int   m_run[3];

   always @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         m_s1 = 1'b0;
         m_s2 = 1'b0;
         for (int i = 0; i < 3; i++) begin
            m_q[i] = 1'b0; m_rn[i] = 1'b1; m_fn[i] = 1'b1; m_run[i] = 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            m_rn[i] = 1'b1;
            m_fn[i] = 1'b1;
            if (CE) begin
               if (m_s2 != m_q[i]) begin
                  m_run[i]++;
                  if (m_run[i] == m_term[i] + 1) begin
                     m_q[i] = ~m_q[i];
                     if (m_q[i]) m_rn[i] = 1'b0;
                     else        m_fn[i] = 1'b0;
                     m_run[i] = 0;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = D;
      end
   end

   // ---------------- compare process ----------------
   bit cmp_en = 1'b0;
   always @(negedge CK) begin
      if (cmp_en) begin
         for (int i = 0; i < 3; i++) begin
            check("model_q", i, q_o[i], m_q[i]);
            check("model_risen", i, rn_o[i], m_rn[i]);
            check("model_falln", i, fn_o[i], m_fn[i]);
            check("strobe_exclusive", i, rn_o[i] | fn_o[i], 1'b1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+2; inputs already set. Checks the closed-form latency
   // edge = TERM+3 for every instance, then returns at posedge+2.
   task automatic expect_edges(input logic from_lvl, input int n);
      for (int e = 1; e <= n; e++) begin
         @(posedge CK);
         #1;
         for (int i = 0; i < 3; i++) begin
            check("lit_q", i, q_o[i], (e >= m_term[i] + 3) ? ~from_lvl : from_lvl);
            check("lit_risen", i, rn_o[i], !(from_lvl == 1'b0 && e == m_term[i] + 3));
            check("lit_falln", i, fn_o[i], !(from_lvl == 1'b1 && e == m_term[i] + 3));
         end
      end
      #1;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge CK);
      #2;
   endtask

   task automatic check_cleared(input string name);
      for (int i = 0; i < 3; i++) begin
         check({name, "_q"}, i, q_o[i], 1'b0);
         check({name, "_risen"}, i, rn_o[i], 1'b1);
         check({name, "_falln"}, i, fn_o[i], 1'b1);
      end
   endtask

   int hold;

   initial begin
      cmp_en = 1'b1;
      // Reset held with D=1: outputs cleared.
      repeat (3) @(posedge CK);
      #1 check_cleared("reset");
      #1 CDN = 1'b1;
      // Rise after full qualification: TERM=4 -> edge 7, TERM=1 -> 4, TERM=16 -> 19.
      expect_edges(1'b0, 20);
      // Fall with D=0 held.
      D = 1'b0;
      expect_edges(1'b1, 20);

      // Bounce: D=1 for three cycles then 0; TERM=4 instance must not move.
      D = 1'b1;
      wait_edges(3);
      D = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge CK);
         #1;
         check("bounce_q", 0, q_o[0], 1'b0);
         check("bounce_risen", 0, rn_o[0], 1'b1);
         check("bounce_falln", 0, fn_o[0], 1'b1);
         #1;
      end
      wait_edges(25);

      // CE gating: CE low on edges 4 and 6 delays TERM=4 rise from 7 to 9.
      D = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         @(posedge CK);
         #1;
         check("ce_q", 0, q_o[0], e >= 9);
         check("ce_risen", 0, rn_o[0], e != 9);
         #1 CE = ((e + 1) == 4 || (e + 1) == 6) ? 1'b0 : 1'b1;
      end
      CE = 1'b1;
      D  = 1'b0;
      wait_edges(25);

      // Async reset mid-qualification (TERM=1 instance is already high).
      D = 1'b1;
      wait_edges(4);
      CDN = 1'b0;
      #1 check_cleared("areset_mid");
      wait_edges(2);
      CDN = 1'b1;
      wait_edges(25);
      // Async reset while every Q is high.
      for (int i = 0; i < 3; i++) check("pre_areset_q", i, q_o[i], 1'b1);
      CDN = 1'b0;
      #1 check_cleared("areset_high");
      wait_edges(2);
      CDN = 1'b1;

      // Randomized phase: held levels with random lengths, sparse CE drops,
      // occasional one-cycle asynchronous resets.
      hold = 0;
      repeat (3000) begin
         @(posedge CK);
         #2;
         if (hold == 0) begin
            D    = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 24);
         end else begin
            hold--;
         end
         CE  = ($urandom_range(0, 7) != 0);
         CDN = ($urandom_range(0, 499) != 0);
      end
      CDN = 1'b1;
      repeat (2) @(negedge CK);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
